// File: rtl/alpha_mdu_pkg.sv
// Shared multiply/divide unit definitions: op encodings, FSM states and the divide-by-zero LO value.
// Used by alu_mdu and by the decoder/hazard logic.
package alpha_mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Sliced down to the datapath width by the user
    localparam int unsigned            MDU_MAX_W   = 128;
    localparam logic [MDU_MAX_W-1:0]   MDU_DIV0_LO = '1;

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/alu_mdu_divstep.sv
// One combinational radix-2 restoring-divide step.
// Partial remainder stays below the divisor, so the W-bit subtraction never wraps.
module alu_mdu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        ge      = shifted >= {1'b0, divisor_i};
        rem_o   = ge ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define ALU_MDU_FAST_MUL_EN for a single-cycle multiply path (IDLE -> FIX -> IDLE).
module alu_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             busy,
    output logic             out_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import alpha_mdu_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               out_done_q, out_done_d;
    logic               div_zero_q, div_zero_d;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem, div_quo;
    logic [2*WIDTH-1:0] prod_mag, prod;

    alu_mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i     (acc_q),
        .quo_i     (mq_q),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    assign in_ready = (state_q == IDLE) && !flush;
    assign busy     = (state_q != IDLE);
    assign out_done = out_done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        accept  = in_valid && in_ready;
        a_neg   = mdu_is_signed(in_op) && in_a[WIDTH-1];
        b_neg   = mdu_is_signed(in_op) && in_b[WIDTH-1];
        a_abs   = a_neg ? -in_a : in_a;
        b_abs   = b_neg ? -in_b : in_b;
        // Multiply keeps the running product in {acc, mq}; multiplier bits shift out of mq
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
`ifdef ALU_MDU_FAST_MUL_EN
        prod_mag = {{WIDTH{1'b0}}, mq_q} * {{WIDTH{1'b0}}, opb_q};
`else
        prod_mag = {acc_q, mq_q};
`endif
        prod = neg_q_q ? -prod_mag : prod_mag;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        div0_d     = div0_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        out_done_d = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (in_op)
                        MDU_MTHI: begin
                            hi_d       = in_a;
                            out_done_d = 1'b1;
                        end
                        MDU_MTLO: begin
                            lo_d       = in_a;
                            out_done_d = 1'b1;
                        end
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            is_div_d = mdu_is_div(in_op);
                            acc_d    = '0;
                            mq_d     = a_abs;
                            opb_d    = b_abs;
                            neg_q_d  = a_neg ^ b_neg;
                            neg_r_d  = a_neg;
                            div0_d   = mdu_is_div(in_op) && (in_b == '0);
                            count_d  = CNT_W'(WIDTH);
                            state_d  = ITER;
`ifdef ALU_MDU_FAST_MUL_EN
                            if (!mdu_is_div(in_op)) begin
                                state_d = FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ITER: begin
                count_d = count_q - CNT_W'(1);
                if (is_div_q) begin
                    acc_d = div_rem;
                    mq_d  = div_quo;
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                if (count_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Divide by zero leaves rem = |a|, so the dividend-sign fix restores a in HI
                if (is_div_q) begin
                    hi_d = neg_r_q ? -acc_q : acc_q;
                    lo_d = div0_q ? MDU_DIV0_LO[WIDTH-1:0] : (neg_q_q ? -mq_q : mq_q);
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                out_done_d = 1'b1;
                div_zero_d = is_div_q && div0_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            hi_d       = hi_q;
            lo_d       = lo_q;
            out_done_d = 1'b0;
            div_zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            out_done_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            div0_q     <= div0_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            out_done_q <= out_done_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule
